// File: rtl/fifo_reader_tx.sv
// Pops bytes from an upstream FIFO and sends each one as an 8N1 serial frame, LSB first.
// Define FIFO_READER_TX_PARITY_EN to add an even-parity bit, which makes the frame 11 bits.
module fifo_reader_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

`ifdef FIFO_READER_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd6
    } state_t;
`endif

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    idx_q, idx_n;
    logic [7:0]    sh_q, sh_n;
    logic          tx_n, pop_n;
    logic          baud_done;

    assign baud_done = (cnt_q == LAST);
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            tx       <= 1'b1;
            fifo_pop <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            idx_q    <= idx_n;
            sh_q     <= sh_n;
            tx       <= tx_n;
            fifo_pop <= pop_n;
        end
    end

    // The counter restarts at zero whenever a bit period ends, which covers every state change.
    always_comb begin
        state_n = state_q;
        cnt_n   = '0;
        idx_n   = idx_q;
        sh_n    = sh_q;
        case (state_q)
            IDLE:  if (!fifo_empty) state_n = POP;
            POP:   state_n = LOAD;
            LOAD: begin
                sh_n    = fifo_data;
                idx_n   = '0;
                state_n = START;
            end
            START: begin
                if (baud_done) state_n = DATA;
                else           cnt_n   = cnt_q + CW'(1);
            end
            DATA: begin
                if (baud_done) begin
                    idx_n = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef FIFO_READER_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
`ifdef FIFO_READER_TX_PARITY_EN
            PARITY: begin
                if (baud_done) state_n = STOP;
                else           cnt_n   = cnt_q + CW'(1);
            end
`endif
            STOP: begin
                if (baud_done) state_n = IDLE;
                else           cnt_n   = cnt_q + CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // tx and fifo_pop are decoded from the next state so that both come straight out of flops.
    always_comb begin
        pop_n = (state_n == POP);
        tx_n  = 1'b1;
        case (state_n)
            START:  tx_n = 1'b0;
            DATA:   tx_n = sh_n[idx_n];
`ifdef FIFO_READER_TX_PARITY_EN
            PARITY: tx_n = ^sh_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fifo_reader_tx.sv
// Directed test of fifo_reader_tx with CLKS_PER_BIT=4: a FIFO model feeds it, and a serial
// monitor decodes tx and checks each frame against the queue of expected bytes.
module tb_fifo_reader_tx;

    localparam int C = 4;
`ifdef FIFO_READER_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int PERIOD = NB * C + 3;

    logic       clk;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       tx;
    logic       busy;
    logic [2:0] state_dbg;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    int         pop_cyc[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         pop_cnt  = 0;
    int         cyc      = 0;
    logic       empty_at_edge = 1'b1;

    fifo_reader_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .tx         (tx),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- upstream FIFO model ----------------
    always @(posedge clk) begin
        empty_at_edge = fifo_empty;
        if (fifo_pop && !reset) begin
            #1;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b, input bit expect_tx);
        fifo_q.push_back(b);
        fifo_empty = 1'b0;
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && fifo_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_done_in_time"}, done, 1);
    endtask

    // ---------------- pop monitor ----------------
    always @(negedge clk) begin
        if (!reset && fifo_pop) begin
            pop_cnt++;
            pop_cyc.push_back(cyc);
            check("pop_only_when_nonempty", empty_at_edge, 0);
        end
    end

    // ---------------- serial monitor / scoreboard ----------------
    task automatic rx_frame();
        logic [NB-1:0] lvl;
        logic [7:0]    data;
        logic [7:0]    req;
        bit            unstable = 1'b0;
        bit            busy_bad = 1'b0;
        lvl = '0;
        for (int s = 0; s < NB; s++) begin
            for (int c = 0; c < C; c++) begin
                if (!(s == 0 && c == 0)) begin
                    @(negedge clk);
                    if (reset) return;
                end
                if (c == 0) lvl[s] = tx;
                else if (tx !== lvl[s]) unstable = 1'b1;
                if (busy !== 1'b1) busy_bad = 1'b1;
            end
        end
        for (int b = 0; b < 8; b++) data[b] = lvl[1 + b];
        check("bit_held_full_period", unstable, 0);
        check("busy_during_frame", busy_bad, 0);
        check("stop_bit", lvl[NB-1], 1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", data);
        end else begin
            req = exp_q.pop_front();
            check("frame_data", data, req);
`ifdef FIFO_READER_TX_PARITY_EN
            check("parity_bit", lvl[9], ^req);
`endif
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && tx === 1'b0) rx_frame();
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int  base;
        bit  bad;
        bit  found;
        reset      = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_pop", fifo_pop, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // single byte
        base = pop_cnt;
        push_byte(8'h55, 1);
        wait_done("single", 200);
        check("single_pop_count", pop_cnt - base, 1);

        // two bytes back-to-back, period between pops
        base = pop_cnt;
        pop_cyc.delete();
        push_byte(8'h55, 1);
        push_byte(8'h07, 1);
        wait_done("pair", 400);
        check("pair_pop_count", pop_cnt - base, 2);
        check("pair_pop_spacing", pop_cyc[1] - pop_cyc[0], PERIOD);

        // empty FIFO for 100 cycles
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("empty_fifo_quiet", bad, 0);

        // reset during DATA bit 2 (cycle 10 of DATA)
        base  = pop_cnt;
        found = 1'b0;
        push_byte(8'hA3, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_pop) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_pop_seen", found, 1);
        repeat (16) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_tx_high", tx, 1);
        check("abort_pop_low", fifo_pop, 0);
        check("abort_busy_low", busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (fifo_pop !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        check("abort_then_quiet", bad, 0);
        check("abort_single_pop", pop_cnt - base, 1);

        // byte already waiting while reset is held: pop on the first edge after release
        @(negedge clk);
        reset = 1'b1;
        push_byte(8'h3C, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("first_pop_after_reset", fifo_pop, 1);
        wait_done("after_reset", 200);

        // three queued bytes
        base = pop_cnt;
        pop_cyc.delete();
        push_byte(8'h00, 1);
        push_byte(8'hFF, 1);
        push_byte(8'h81, 1);
        wait_done("triple", 600);
        check("triple_pop_count", pop_cnt - base, 3);
        check("triple_spacing_1", pop_cyc[1] - pop_cyc[0], PERIOD);
        check("triple_spacing_2", pop_cyc[2] - pop_cyc[1], PERIOD);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("final_tx_idle", tx, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_reader_tx.md
FIFO_READER_TX -- requirements
Module: fifo_reader_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104: clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port fifo_empty  input  1  high when the upstream byte FIFO holds no data.
REQ-005 SHALL have port fifo_data  input  8  FIFO read data, valid on the cycle after a pop.
REQ-006 SHALL have port fifo_pop  output  1  registered one-cycle pop strobe to the FIFO.
REQ-007 SHALL have port tx  output  1  serial line, idle high.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL implement states IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
REQ-010 IDLE: tx=1, fifo_pop=0; if fifo_empty=0 at a rising edge, SHALL go to POP.
REQ-011 POP: fifo_pop=1 for exactly one cycle; next state LOAD unconditionally.
REQ-012 LOAD: fifo_pop=0; fifo_data SHALL be captured into an 8-bit shift register at the edge leaving LOAD; next START.
REQ-013 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-014 DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; a 3-bit index counts 0..7, leaving on wrap from 7.
REQ-015 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-016 Baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, counting 0..CLKS_PER_BIT-1, cleared on every state change.
REQ-017 fifo_pop SHALL never be asserted while fifo_empty was 1 at the deciding edge; at most one pop per frame.
REQ-018 Back-to-back: after STOP ends, IDLE SHALL last at least one cycle before the next POP; minimum frame-to-frame period = (10 or 11)*CLKS_PER_BIT + 3 cycles.
REQ-019 fifo_empty rising during POP/LOAD/frame SHALL not affect the frame in progress.
REQ-020 tx and fifo_pop SHALL be driven from flops (glitch-free).

Reset
REQ-021 reset=1 SHALL immediately force state=IDLE, tx=1, fifo_pop=0, busy=0, counters and shift register to 0.
REQ-022 Reset mid-frame SHALL abort the frame; a byte already popped is discarded, no re-pop.
REQ-023 After reset deasserts, first possible POP SHALL be at the first rising edge with fifo_empty=0.

Configuration
REQ-024 Macro FIFO_READER_TX_PARITY_EN SHALL control the parity bit.
REQ-025 Defined: PARITY state between DATA and STOP, tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles; frame = 11 bit times.
REQ-026 Undefined: no PARITY state or logic; DATA goes directly to STOP; frame = 10 bit times.

Verification (CLKS_PER_BIT=4)
REQ-027 Single byte 0x55, parity off: fifo_empty low one frame -> one pop; tx = 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 cycles), busy high throughout, then tx=1.
REQ-028 Parity on, bytes 0x55 then 0x07: parity bits 0 then 1; 44 cycles per frame; exactly two pops, separated by 44+3 cycles.
REQ-029 fifo_empty held 1 for 100 cycles: fifo_pop never asserted, tx=1, busy=0.
REQ-030 Reset asserted at cycle 10 of DATA for 0xA3: tx=1 and fifo_pop=0 same cycle, busy=0; after release with fifo_empty=1 no further activity.
REQ-031 Three bytes 0x00, 0xFF, 0x81 queued: three pops, frames transmitted in order, LSB first, no pop while fifo_empty=1.
